// File: rtl/rpn_evaluator.sv
// Postfix (RPN) evaluator: pops operands off a fixed-depth stack for each operator token
// and returns the top of the stack on '=' through a separate stb/ack result port.
module rpn_evaluator #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 20,
   parameter int PTR_W = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             input_stb,
   input  logic [WIDTH-1:0] input_data,
   input  logic             is_input_operator,
   output logic             input_ack,
   output logic             result_stb,
   output logic [WIDTH-1:0] result_data,
   input  logic             result_ack,
   output logic             error,
   output logic [1:0]       err_code,
   output logic [PTR_W-1:0] depth
);

   typedef enum logic [2:0] {IDLE, EXEC, RESULT, ACK, DRAIN} state_t;

   localparam logic [PTR_W-1:0] FULL_P = PTR_W'(DEPTH);
   localparam logic [2:0] OP_MUL = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_SUB = 3'd3;
   localparam logic [2:0] OP_EQ  = 3'd4;

   state_t           state_r, state_s;
   logic [WIDTH-1:0] data_r;
   logic             op_r;
   logic             ack_r;
   logic             res_stb_r;
   logic [WIDTH-1:0] res_data_r;
   logic             err_r;
   logic [1:0]       code_r;
   logic [PTR_W-1:0] depth_r;
   logic [WIDTH-1:0] stack_r [DEPTH];

   logic [2:0]       opc_s;
   logic [PTR_W-1:0] top_idx_s, nxt_idx_s;
   logic [WIDTH-1:0] a_s, b_s, alu_s;
   logic             exec_s, arith_s, push_ok_s, arith_ok_s, err_set_s;
   logic [1:0]       err_code_s;

   assign input_ack   = ack_r;
   assign result_stb  = res_stb_r;
   assign result_data = res_data_r;
   assign error       = err_r;
   assign err_code    = code_r;
   assign depth       = depth_r;

   // Operand fetch, ALU and error classification for the token held in EXEC.
   always_comb begin
      opc_s      = data_r[2:0];
      top_idx_s  = depth_r - PTR_W'(1);
      nxt_idx_s  = depth_r - PTR_W'(2);
      b_s        = stack_r[top_idx_s];
      a_s        = stack_r[nxt_idx_s];
      exec_s     = (state_r == EXEC);
      arith_s    = op_r && ((opc_s == OP_MUL) || (opc_s == OP_ADD) || (opc_s == OP_SUB));
      push_ok_s  = exec_s && !op_r && !err_r && (depth_r != FULL_P);
      arith_ok_s = exec_s && arith_s && !err_r && (depth_r >= PTR_W'(2));
      err_set_s  = 1'b0;
      err_code_s = 2'b00;
      case (opc_s)
         OP_MUL:  alu_s = a_s * b_s;
         OP_ADD:  alu_s = a_s + b_s;
         OP_SUB:  alu_s = a_s - b_s;
         default: alu_s = {WIDTH{1'b0}};
      endcase
      if (exec_s && !err_r) begin
         if (!op_r) begin
            if (depth_r == FULL_P) begin
               err_set_s  = 1'b1;
               err_code_s = 2'b10;
            end else begin
               err_set_s  = 1'b0;
            end
         end else if (arith_s) begin
            if (depth_r < PTR_W'(2)) begin
               err_set_s  = 1'b1;
               err_code_s = 2'b01;
            end else begin
               err_set_s  = 1'b0;
            end
         end else if (opc_s == OP_EQ) begin
            if (depth_r != PTR_W'(1)) begin
               err_set_s  = 1'b1;
               err_code_s = 2'b11;
            end else begin
               err_set_s  = 1'b0;
            end
         end else begin
            err_set_s  = 1'b1;
            err_code_s = 2'b11;
         end
      end else begin
         err_set_s = 1'b0;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    if (input_stb) state_s = EXEC; else state_s = IDLE;
         EXEC:    if (op_r && (opc_s == OP_EQ)) state_s = RESULT; else state_s = ACK;
         RESULT:  if (res_stb_r && result_ack) state_s = ACK; else state_s = RESULT;
         ACK:     state_s = DRAIN;
         DRAIN:   if (!input_stb) state_s = IDLE; else state_s = DRAIN;
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_r <= IDLE;
      else     state_r <= state_s;
   end

   // Token latch, handshake outputs, depth and sticky error.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         data_r     <= {WIDTH{1'b0}};
         op_r       <= 1'b0;
         ack_r      <= 1'b0;
         res_stb_r  <= 1'b0;
         res_data_r <= {WIDTH{1'b0}};
         err_r      <= 1'b0;
         code_r     <= 2'b00;
         depth_r    <= {PTR_W{1'b0}};
      end else begin
         if (err_set_s) begin
            err_r  <= 1'b1;
            code_r <= err_code_s;
         end
         if (push_ok_s)  depth_r <= depth_r + PTR_W'(1);
         if (arith_ok_s) depth_r <= depth_r - PTR_W'(1);
         case (state_r)
            IDLE: begin
               if (input_stb) begin
                  data_r <= input_data;
                  op_r   <= is_input_operator;
               end
            end
            EXEC:   ack_r <= !(op_r && (opc_s == OP_EQ));
            RESULT: begin
               if (!res_stb_r) begin
                  res_stb_r  <= 1'b1;
                  res_data_r <= err_r ? {WIDTH{1'b0}} : b_s;
               end else if (result_ack) begin
                  res_stb_r <= 1'b0;
                  depth_r   <= {PTR_W{1'b0}};
                  err_r     <= 1'b0;
                  code_r    <= 2'b00;
                  ack_r     <= 1'b1;
               end
            end
            ACK:     ack_r <= 1'b0;
            default: ack_r <= 1'b0;
         endcase
      end
   end

   // Operand storage; contents beyond depth are don't-care, so no reset.
   always_ff @(posedge CLK) begin
      if (push_ok_s)  stack_r[depth_r]   <= data_r;
      if (arith_ok_s) stack_r[nxt_idx_s] <= alu_s;
   end

endmodule

// File: tb/tb_rpn_evaluator.sv
// Self-checking bench for rpn_evaluator: hand-computed vector table, corner sequences
// and random expressions checked against a queue-based postfix model.
module tb_rpn_evaluator;

   logic        CLK = 1'b0;
   logic        RST;
   logic        input_stb;
   logic [31:0] input_data;
   logic        is_input_operator;
   logic        input_ack;
   logic        result_stb;
   logic [31:0] result_data;
   logic        result_ack;
   logic        error;
   logic [1:0]  err_code;
   logic [4:0]  depth;

   rpn_evaluator dut (
      .CLK(CLK), .RST(RST), .input_stb(input_stb), .input_data(input_data),
      .is_input_operator(is_input_operator), .input_ack(input_ack),
      .result_stb(result_stb), .result_data(result_data), .result_ack(result_ack),
      .error(error), .err_code(err_code), .depth(depth)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;
   int ack_cnt = 0;

   always @(posedge CLK) if (input_ack) ack_cnt <= ack_cnt + 1;

   typedef struct packed {
      logic [31:0] data;
      logic        is_op;
      logic [4:0]  exp_depth;
      logic        exp_err;
      logic [1:0]  exp_code;
      logic [31:0] exp_res;
   } vec_t;

   vec_t vecs[$];

   logic [31:0] cap_res;
   logic        cap_err;
   logic [1:0]  cap_code;
   logic        got_res;

   logic [31:0] m_stack[$];
   logic        m_err;
   logic [1:0]  m_code;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void add(input logic [31:0] d, input logic op, input logic [4:0] dep,
                               input logic er, input logic [1:0] cd, input logic [31:0] res);
      vec_t v;
      v = '{data: d, is_op: op, exp_depth: dep, exp_err: er, exp_code: cd, exp_res: res};
      vecs.push_back(v);
   endfunction

   // Present one token, take any result, wait (bounded) for input_ack, then release.
   task automatic send(input logic [31:0] d, input logic op);
      logic ok;
      ok = 1'b0;
      got_res = 1'b0;
      @(negedge CLK);
      input_stb = 1'b1;
      input_data = d;
      is_input_operator = op;
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         if (result_stb && !got_res) begin
            cap_res = result_data;
            cap_err = error;
            cap_code = err_code;
            got_res = 1'b1;
            result_ack = 1'b1;
         end else begin
            result_ack = 1'b0;
         end
         if (input_ack) begin
            ok = 1'b1;
            break;
         end
      end
      input_stb = 1'b0;
      result_ack = 1'b0;
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL ack_timeout: got no input_ack expected one for token %h", d);
      end
      @(negedge CLK);
   endtask

   function automatic void model_token(input logic [31:0] d, input logic op);
      logic [31:0] a, b;
      if (!op) begin
         if (!m_err) begin
            if (m_stack.size() == 20) begin m_err = 1'b1; m_code = 2'b10; end
            else m_stack.push_back(d);
         end
      end else if (d[2:0] >= 3'd1 && d[2:0] <= 3'd3 && d[2:0] != 3'd4) begin
         if (!m_err) begin
            if (m_stack.size() < 2) begin m_err = 1'b1; m_code = 2'b01; end
            else begin
               b = m_stack.pop_back();
               a = m_stack.pop_back();
               if (d[2:0] == 3'd1)      m_stack.push_back(a * b);
               else if (d[2:0] == 3'd2) m_stack.push_back(a + b);
               else                     m_stack.push_back(a - b);
            end
         end
      end else if (d[2:0] != 3'd4) begin
         if (!m_err) begin m_err = 1'b1; m_code = 2'b11; end
      end
   endfunction

   task automatic check_result(input string name, input logic [31:0] res, input logic er,
                               input logic [1:0] cd);
      check({name, "_got_result"}, {31'd0, got_res}, 32'd1);
      check({name, "_result"}, cap_res, res);
      check({name, "_error"}, {31'd0, cap_err}, {31'd0, er});
      check({name, "_err_code"}, {30'd0, cap_code}, {30'd0, cd});
      check({name, "_depth_after"}, {27'd0, depth}, 32'd0);
      check({name, "_error_after"}, {31'd0, error}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {26'd0, input_ack, result_stb, error, err_code, (result_data != 32'd0)},
            32'd0);
      check({name, "_depth"}, {27'd0, depth}, 32'd0);
   endtask

   initial begin
      int c0, nt;
      logic [31:0] r, exp_r;
      logic        exp_e;
      logic [1:0]  exp_c;

      RST = 1'b1;
      input_stb = 1'b0;
      input_data = 32'd0;
      is_input_operator = 1'b0;
      result_ack = 1'b0;
      repeat (3) @(negedge CLK);
      check_reset_outputs("reset_state");
      RST = 1'b0;

      add(32'd3, 1'b0, 5'd1, 1'b0, 2'b00, 32'd0);
      add(32'd4, 1'b0, 5'd2, 1'b0, 2'b00, 32'd0);
      add(32'd2, 1'b1, 5'd1, 1'b0, 2'b00, 32'd0);
      add(32'd2, 1'b0, 5'd2, 1'b0, 2'b00, 32'd0);
      add(32'd1, 1'b1, 5'd1, 1'b0, 2'b00, 32'd0);
      add(32'd4, 1'b1, 5'd0, 1'b0, 2'b00, 32'd14);
      add(32'd7, 1'b0, 5'd1, 1'b0, 2'b00, 32'd0);
      add(32'd2, 1'b0, 5'd2, 1'b0, 2'b00, 32'd0);
      add(32'd3, 1'b1, 5'd1, 1'b0, 2'b00, 32'd0);
      add(32'd4, 1'b1, 5'd0, 1'b0, 2'b00, 32'd5);
      add(32'd2, 1'b0, 5'd1, 1'b0, 2'b00, 32'd0);
      add(32'd7, 1'b0, 5'd2, 1'b0, 2'b00, 32'd0);
      add(32'd3, 1'b1, 5'd1, 1'b0, 2'b00, 32'd0);
      add(32'd4, 1'b1, 5'd0, 1'b0, 2'b00, 32'hFFFFFFFB);
      add(32'd65536, 1'b0, 5'd1, 1'b0, 2'b00, 32'd0);
      add(32'd65536, 1'b0, 5'd2, 1'b0, 2'b00, 32'd0);
      add(32'd1, 1'b1, 5'd1, 1'b0, 2'b00, 32'd0);
      add(32'd4, 1'b1, 5'd0, 1'b0, 2'b00, 32'd0);
      add(32'h7FFFFFFF, 1'b0, 5'd1, 1'b0, 2'b00, 32'd0);
      add(32'd1, 1'b0, 5'd2, 1'b0, 2'b00, 32'd0);
      add(32'd2, 1'b1, 5'd1, 1'b0, 2'b00, 32'd0);
      add(32'd4, 1'b1, 5'd0, 1'b0, 2'b00, 32'h80000000);
      add(32'd2, 1'b1, 5'd0, 1'b1, 2'b01, 32'd0);
      add(32'd5, 1'b0, 5'd0, 1'b1, 2'b01, 32'd0);
      add(32'd4, 1'b1, 5'd0, 1'b1, 2'b01, 32'd0);
      add(32'd5, 1'b0, 5'd1, 1'b0, 2'b00, 32'd0);
      add(32'd6, 1'b1, 5'd1, 1'b1, 2'b11, 32'd0);
      add(32'd3, 1'b1, 5'd1, 1'b1, 2'b11, 32'd0);
      add(32'd4, 1'b1, 5'd0, 1'b1, 2'b11, 32'd0);
      add(32'd1, 1'b0, 5'd1, 1'b0, 2'b00, 32'd0);
      add(32'd2, 1'b0, 5'd2, 1'b0, 2'b00, 32'd0);
      add(32'd4, 1'b1, 5'd0, 1'b1, 2'b11, 32'd0);
      for (int i = 1; i <= 21; i++)
         add(32'(i), 1'b0, (i > 20) ? 5'd20 : 5'(i), (i > 20), (i > 20) ? 2'b10 : 2'b00, 32'd0);
      add(32'd4, 1'b1, 5'd0, 1'b1, 2'b10, 32'd0);

      c0 = ack_cnt;
      foreach (vecs[i]) begin
         vec_t v;
         v = vecs[i];
         send(v.data, v.is_op);
         if (v.is_op && v.data[2:0] == 3'd4) begin
            check_result($sformatf("vec%0d", i), v.exp_res, v.exp_err, v.exp_code);
         end else begin
            check($sformatf("vec%0d_depth", i), {27'd0, depth}, {27'd0, v.exp_depth});
            check($sformatf("vec%0d_err", i), {29'd0, error, err_code},
                  {29'd0, v.exp_err, v.exp_code});
         end
      end
      check("table_ack_pulses", 32'(ack_cnt - c0), 32'(vecs.size()));

      // Token whose stb stays high 6 cycles past its ack must be consumed once.
      c0 = ack_cnt;
      @(negedge CLK);
      input_stb = 1'b1;
      input_data = 32'd9;
      is_input_operator = 1'b0;
      for (int i = 0; i < 60 && !input_ack; i++) @(negedge CLK);
      repeat (6) @(negedge CLK);
      check("hold_stb_acks", 32'(ack_cnt - c0), 32'd1);
      check("hold_stb_depth", {27'd0, depth}, 32'd1);
      input_stb = 1'b0;
      @(negedge CLK);
      send(32'd4, 1'b1);
      check_result("hold_stb_eq", 32'd9, 1'b0, 2'b00);

      // Reset in the middle of a transfer, with operands on the stack.
      send(32'd5, 1'b0);
      send(32'd6, 1'b0);
      check("pre_reset_depth", {27'd0, depth}, 32'd2);
      c0 = ack_cnt;
      @(negedge CLK);
      input_stb = 1'b1;
      input_data = 32'd7;
      @(posedge CLK);
      #1 RST = 1'b1;
      #1 check_reset_outputs("async_reset");
      input_stb = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      check("reset_dropped_token", 32'(ack_cnt - c0), 32'd0);
      send(32'd1, 1'b0);
      send(32'd1, 1'b0);
      send(32'd2, 1'b1);
      send(32'd4, 1'b1);
      check_result("post_reset", 32'd2, 1'b0, 2'b00);

      // Random expressions against the queue model.
      for (int e = 0; e < 40; e++) begin
         m_stack.delete();
         m_err = 1'b0;
         m_code = 2'b00;
         nt = $urandom_range(1, 12);
         for (int t = 0; t < nt; t++) begin
            int k;
            logic [31:0] d;
            logic op;
            k = $urandom_range(0, 19);
            if (k < 10) begin
               op = 1'b0;
               d = (k < 5) ? 32'($urandom_range(0, 100)) : $urandom;
            end else if (k < 19) begin
               op = 1'b1;
               d = {$urandom_range(0, 1) ? 29'h1FFFFFFF : 29'd0, 3'($urandom_range(1, 3))};
            end else begin
               op = 1'b1;
               r = 32'($urandom_range(0, 3));
               d = (r == 32'd0) ? 32'd0 : r + 32'd4;
            end
            model_token(d, op);
            send(d, op);
            check($sformatf("rand%0d_%0d_depth", e, t), {27'd0, depth}, 32'(m_stack.size()));
            check($sformatf("rand%0d_%0d_err", e, t), {29'd0, error, err_code},
                  {29'd0, m_err, m_code});
         end
         if (!m_err && m_stack.size() != 1) begin
            m_err = 1'b1;
            m_code = 2'b11;
         end
         exp_e = m_err;
         exp_c = m_code;
         exp_r = m_err ? 32'd0 : m_stack[m_stack.size() - 1];
         send(32'd4, 1'b1);
         check_result($sformatf("rand%0d_eq", e), exp_r, exp_e, exp_c);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
